alarm_controller: RTL and testbench

Multi-channel alarm sequencer and next-generation alarm-state block of the alarm clock. Takes per-channel time/alarm match and enable levels, a one-cycle time-base tick and user dismiss/snooze pulses. Runs a per-channel ring/snooze/timeout state machine with snooze limiting and missed-alarm flags. Drives the buzzer and per-channel status for the display path.

---
 rtl/alarm_controller.sv | 154 +++++++++++++++
 tb/tb_alarm_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Multi-channel alarm sequencer: per-channel ring/snooze/timeout FSM driving buzzer and status.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state, snooze-use limiting).
module alarm_controller #(
  parameter int NUM_ALARMS    = 4,
  parameter int SNOOZE_TICKS  = 300,
  parameter int TIMEOUT_TICKS = 60,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [NUM_ALARMS-1:0] match,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  dismiss,
  input  logic                  snooze,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic [NUM_ALARMS-1:0] snoozed,
  output logic [NUM_ALARMS-1:0] missed,
  output logic                  buzzer
);

  localparam int MAX_TICKS = (SNOOZE_TICKS > TIMEOUT_TICKS) ? SNOOZE_TICKS : TIMEOUT_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
  localparam int UW = $clog2(MAX_SNOOZE + 1);
  localparam logic [UW-1:0] USE_LIMIT   = UW'(MAX_SNOOZE);
  localparam logic [UW-1:0] USE_ONE     = UW'(1);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_TICKS);
  logic [UW-1:0] useQ [NUM_ALARMS];
  logic [UW-1:0] useD [NUM_ALARMS];
`else
  typedef enum logic {IDLE, RINGING} state_t;
  logic unusedSnooze;
  assign unusedSnooze = snooze ^ (MAX_SNOOZE == 0);
`endif

  state_t                stateQ [NUM_ALARMS];
  state_t                stateD [NUM_ALARMS];
  logic [CW-1:0]         cntQ   [NUM_ALARMS];
  logic [CW-1:0]         cntD   [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] matchQ;
  logic [NUM_ALARMS-1:0] missedQ;
  logic [NUM_ALARMS-1:0] missedD;

  // matchQ resets high so a match already present at reset release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matchQ  <= '1;
      missedQ <= '0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        stateQ[i] <= IDLE;
        cntQ[i]   <= '0;
`ifdef ALARM_SNOOZE_EN
        useQ[i]   <= '0;
`endif
      end
    end else begin
      matchQ  <= match;
      missedQ <= missedD;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        stateQ[i] <= stateD[i];
        cntQ[i]   <= cntD[i];
`ifdef ALARM_SNOOZE_EN
        useQ[i]   <= useD[i];
`endif
      end
    end
  end

  always_comb begin
    missedD = missedQ;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      stateD[i] = stateQ[i];
      cntD[i]   = cntQ[i];
`ifdef ALARM_SNOOZE_EN
      useD[i]   = useQ[i];
`endif
      if (!alarm_en[i]) begin
        stateD[i]  = IDLE;
        missedD[i] = 1'b0;
      end else if (dismiss) begin
        stateD[i]  = IDLE;
        missedD[i] = 1'b0;
`ifdef ALARM_SNOOZE_EN
        useD[i]    = '0;
`endif
      end else begin
        case (stateQ[i])
          RINGING: begin
`ifdef ALARM_SNOOZE_EN
            if (snooze && (useQ[i] < USE_LIMIT)) begin
              stateD[i] = SNOOZED;
              cntD[i]   = SNOOZE_LOAD;
              useD[i]   = useQ[i] + USE_ONE;
            end else
`endif
            if (tick) begin
              if (cntQ[i] == TIMEOUT_LAST) begin
                stateD[i]  = IDLE;
                missedD[i] = 1'b1;
`ifdef ALARM_SNOOZE_EN
                useD[i]    = '0;
`endif
              end else begin
                cntD[i] = cntQ[i] + CNT_ONE;
              end
            end
          end
`ifdef ALARM_SNOOZE_EN
          SNOOZED: begin
            if (tick) begin
              if (cntQ[i] == CNT_ONE) begin
                stateD[i] = RINGING;
                cntD[i]   = '0;
              end else begin
                cntD[i] = cntQ[i] - CNT_ONE;
              end
            end
          end
`endif
          IDLE: begin
            if (match[i] && !matchQ[i]) begin
              stateD[i] = RINGING;
              cntD[i]   = '0;
`ifdef ALARM_SNOOZE_EN
              useD[i]   = '0;
`endif
            end
          end
          default: stateD[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ringing = '0;
    snoozed = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      ringing[i] = (stateQ[i] == RINGING);
`ifdef ALARM_SNOOZE_EN
      snoozed[i] = (stateQ[i] == SNOOZED);
`endif
    end
  end

  assign missed = missedQ;
  assign buzzer = |ringing;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: time-remaining behavioural model checked every cycle, plus directed literal checks.
module tb_alarm_controller;
  localparam int N  = 2;
  localparam int ST = 3;
  localparam int TT = 5;
  localparam int MS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, tick, dismiss, snooze, buzzer;
  logic [N-1:0] match, alarmEn, ringing, snoozed, missed;
  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  alarm_controller #(
    .NUM_ALARMS(N), .SNOOZE_TICKS(ST), .TIMEOUT_TICKS(TT), .MAX_SNOOZE(MS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .match(match), .alarm_en(alarmEn),
    .dismiss(dismiss), .snooze(snooze), .ringing(ringing), .snoozed(snoozed),
    .missed(missed), .buzzer(buzzer)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Model: each active channel tracks how many ticks remain before it changes mode
  bit mRing [N], mSnz [N], mMissed [N], mPrev [N];
  int mLeft [N], mUsed [N];
  bit trig;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mRing[i] = 0; mSnz[i] = 0; mMissed[i] = 0; mPrev[i] = 1;
        mLeft[i] = 0; mUsed[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        trig = alarmEn[i] && match[i] && !mPrev[i];
        mPrev[i] = match[i];
        if (!alarmEn[i]) begin
          mRing[i] = 0; mSnz[i] = 0; mMissed[i] = 0;
        end else if (dismiss) begin
          mRing[i] = 0; mSnz[i] = 0; mMissed[i] = 0; mUsed[i] = 0;
        end else if (mRing[i]) begin
          if (SNZ && snooze && mUsed[i] < MS) begin
            mRing[i] = 0; mSnz[i] = 1; mLeft[i] = ST; mUsed[i]++;
          end else if (tick) begin
            mLeft[i]--;
            if (mLeft[i] == 0) begin
              mRing[i] = 0; mMissed[i] = 1; mUsed[i] = 0;
            end
          end
        end else if (mSnz[i]) begin
          if (tick) begin
            mLeft[i]--;
            if (mLeft[i] == 0) begin
              mSnz[i] = 0; mRing[i] = 1; mLeft[i] = TT;
            end
          end
        end else if (trig) begin
          mRing[i] = 1; mLeft[i] = TT; mUsed[i] = 0;
        end
      end
    end
  end

  logic [N-1:0] eR, eS, eM;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      eR[i] = mRing[i]; eS[i] = mSnz[i]; eM[i] = mMissed[i];
    end
    check("model_ringing", ringing, eR);
    check("model_snoozed", snoozed, eS);
    check("model_missed", missed, eM);
    check("model_buzzer", buzzer, |eR);
  end

  task automatic pulseTick();
    tick = 1'b1; @(negedge clk); tick = 1'b0;
  endtask
  task automatic pulseSnooze();
    snooze = 1'b1; @(negedge clk); snooze = 1'b0;
  endtask
  task automatic pulseDismiss();
    dismiss = 1'b1; @(negedge clk); dismiss = 1'b0;
  endtask
  task automatic retrigger(input logic [N-1:0] bits);
    match = '0; @(negedge clk);
    match = bits; @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    match = 2'b01; alarmEn = 2'b01;
    repeat (3) @(negedge clk);
    check("reset_ringing", ringing, 2'b00);
    check("reset_missed", missed, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("no_trigger_at_release", ringing, 2'b00);

    retrigger(2'b01);
    check("trigger_ringing", ringing, 2'b01);
    check("trigger_buzzer", buzzer, 1'b1);

    repeat (4) pulseTick();
    check("ring_before_timeout", ringing, 2'b01);
    pulseTick();
    check("timeout_ringing", ringing, 2'b00);
    check("timeout_missed", missed, 2'b01);
    pulseDismiss();
    check("dismiss_clears_missed", missed, 2'b00);
    @(negedge clk);
    check("no_retrigger_same_match", ringing, 2'b00);

    retrigger(2'b01);
    pulseSnooze();
`ifdef ALARM_SNOOZE_EN
    check("snooze_snoozed", snoozed, 2'b01);
    check("snooze_buzzer", buzzer, 1'b0);
    repeat (2) pulseTick();
    check("snooze_still", snoozed, 2'b01);
    pulseTick();
    check("rering_ringing", ringing, 2'b01);
    check("rering_snoozed", snoozed, 2'b00);
    pulseSnooze();
    repeat (3) pulseTick();
    check("second_rering", ringing, 2'b01);
    pulseSnooze();
    check("limit_ringing", ringing, 2'b01);
    check("limit_snoozed", snoozed, 2'b00);
    repeat (4) pulseTick();
    check("limit_still_ringing", ringing, 2'b01);
    pulseDismiss();
    check("limit_dismissed", ringing, 2'b00);
`else
    check("nosnz_ringing", ringing, 2'b01);
    check("nosnz_snoozed", snoozed, 2'b00);
    repeat (4) pulseTick();
    check("nosnz_still_ringing", ringing, 2'b01);
    pulseTick();
    check("nosnz_timeout", ringing, 2'b00);
    check("nosnz_missed", missed, 2'b01);
    pulseDismiss();
`endif

    alarmEn = 2'b11;
    retrigger(2'b11);
    check("both_ringing", ringing, 2'b11);
    dismiss = 1'b1; snooze = 1'b1;
    @(negedge clk);
    dismiss = 1'b0; snooze = 1'b0;
    check("dismiss_wins_ringing", ringing, 2'b00);
    check("dismiss_wins_snoozed", snoozed, 2'b00);

    retrigger(2'b10);
    check("ch1_ringing", ringing, 2'b10);
    pulseSnooze();
`ifdef ALARM_SNOOZE_EN
    check("ch1_snoozed", snoozed, 2'b10);
`else
    check("ch1_snooze_ignored", ringing, 2'b10);
`endif
    alarmEn = 2'b01;
    @(negedge clk);
    check("disable_ringing", ringing, 2'b00);
    check("disable_snoozed", snoozed, 2'b00);
    alarmEn = 2'b11;

    retrigger(2'b01);
    check("pre_reset_ringing", ringing, 2'b01);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ringing", ringing, 2'b00);
    check("async_reset_buzzer", buzzer, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_no_trigger", ringing, 2'b00);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
